// File: rtl/fifo_bank_reader_pkg.sv
// Shared defaults for the FIFO-bank pop-side controller.
package fifo_bank_reader_pkg;
  localparam int DEF_NUM_FLOWS  = 16;
  localparam int DEF_DEPTH      = 10;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/fifo_bank_reader_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter
  import fifo_bank_reader_pkg::*;
#(
  parameter  int NUM_FLOWS = DEF_NUM_FLOWS,
  localparam int IDX_WIDTH = $clog2(NUM_FLOWS + 1),
  localparam int SEL_WIDTH = $clog2(NUM_FLOWS)
) (
  input  logic [NUM_FLOWS-1:0] req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_FLOWS-1:0] gnt,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 gnt_valid
);

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // k = NUM_FLOWS revisits ptr itself last, so a lone requester at ptr is still served
    for (int k = 1; k <= NUM_FLOWS; k++) begin
      logic [SEL_WIDTH-1:0] sel;
      sel = SEL_WIDTH'((int'(ptr) + k) % NUM_FLOWS);
      if (!gnt_valid && req[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_WIDTH'(sel);
        gnt[sel]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_bank_reader.sv
// Pop-side controller for the per-flow FIFO bank: snooped occupancy, RR pop,
// registered dequeue port and consumer reinsert path sharing the pop flow-id bus.
module fifo_bank_reader
  import fifo_bank_reader_pkg::*;
#(
  parameter  int NUM_FLOWS  = DEF_NUM_FLOWS,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int IDX_WIDTH  = $clog2(NUM_FLOWS + 1),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__push_valid,
  input  logic [IDX_WIDTH-1:0]  i__push_flow_id,
  input  logic                  i__push_flow_not_full,
  output logic                  o__pop,
  output logic [IDX_WIDTH-1:0]  o__pop_flow_id,
  input  logic [DATA_WIDTH-1:0] i__pop_data,
  input  logic                  i__pop_valid,
  output logic                  o__reinsert_valid,
  output logic [DATA_WIDTH-1:0] o__reinsert_data,
  output logic                  o__deq_valid,
  output logic [IDX_WIDTH-1:0]  o__deq_flow_id,
  output logic [DATA_WIDTH-1:0] o__deq_data,
  input  logic                  i__deq_ready,
  input  logic                  i__rein_valid,
  input  logic [IDX_WIDTH-1:0]  i__rein_flow_id,
  input  logic [DATA_WIDTH-1:0] i__rein_data,
  output logic                  o__rein_ready,
  output logic                  o__err
);

  logic [CNT_WIDTH-1:0] cnt [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] nonempty, gnt;
  logic [IDX_WIDTH-1:0] ptr, gnt_idx;
  logic                 gnt_valid;
  logic                 push_acc, rein_in_range, rein_room, rein_fire, pop_fire;
  logic [CNT_WIDTH-1:0] rein_cnt;

  assign push_acc      = i__push_valid && i__push_flow_not_full;
  assign rein_in_range = i__rein_flow_id < IDX_WIDTH'(NUM_FLOWS);

  always_comb begin
    rein_cnt = '0;
    for (int f = 0; f < NUM_FLOWS; f++)
      if (i__rein_flow_id == IDX_WIDTH'(f)) rein_cnt = cnt[f];
  end

  assign rein_room = ({1'b0, rein_cnt}
                      + (CNT_WIDTH+1)'(push_acc && (i__push_flow_id == i__rein_flow_id)))
                     < (CNT_WIDTH+1)'(DEPTH);

  // Same-flow push and reinsert collide in the bank (push wins), so refuse the reinsert
  assign o__rein_ready = !reset && i__rein_valid && rein_in_range && rein_room
                         && !(i__push_valid && (i__push_flow_id == i__rein_flow_id));
  assign rein_fire     = o__rein_ready;
  assign pop_fire      = !reset && !rein_fire && (!o__deq_valid || i__deq_ready) && gnt_valid;

  assign o__pop            = pop_fire;
  assign o__reinsert_valid = rein_fire;
  assign o__reinsert_data  = rein_fire ? i__rein_data : '0;
  assign o__pop_flow_id    = rein_fire ? i__rein_flow_id : (pop_fire ? gnt_idx : '0);

  rr_arbiter #(.NUM_FLOWS(NUM_FLOWS)) u_arb (
    .req      (nonempty),
    .ptr      (ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  for (genvar f = 0; f < NUM_FLOWS; f++) begin : g_cnt
    logic push_hit, rein_hit, pop_hit;
    logic [CNT_WIDTH-1:0] count;
    assign push_hit    = push_acc && (i__push_flow_id == IDX_WIDTH'(f));
    assign rein_hit    = rein_fire && (i__rein_flow_id == IDX_WIDTH'(f));
    assign pop_hit     = pop_fire && gnt[f];
    assign nonempty[f] = count != '0;
    assign cnt[f]      = count;
    always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else       count <= count + CNT_WIDTH'(push_hit) + CNT_WIDTH'(rein_hit)
                                - CNT_WIDTH'(pop_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o__deq_valid   <= 1'b0;
      o__deq_flow_id <= '0;
      o__deq_data    <= '0;
      o__err         <= 1'b0;
      ptr            <= IDX_WIDTH'(NUM_FLOWS - 1);
    end else begin
      if (pop_fire) begin
        o__deq_valid   <= 1'b1;
        o__deq_flow_id <= gnt_idx;
        o__deq_data    <= i__pop_data;
        ptr            <= gnt_idx;
      end else if (i__deq_ready) begin
        o__deq_valid   <= 1'b0;
        o__deq_flow_id <= '0;
        o__deq_data    <= '0;
      end
      if (pop_fire && !i__pop_valid) o__err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_bank_reader.sv
// Scoreboard bench for fifo_bank_reader with a small behavioural FIFO bank model.
module tb_fifo_bank_reader;
  localparam int NF = 16, D = 10, DW = 8, IW = 5;

  logic clk = 1'b0, reset;
  logic          i__push_valid, i__push_flow_not_full, i__pop_valid, i__deq_ready, i__rein_valid;
  logic [IW-1:0] i__push_flow_id, i__rein_flow_id;
  logic [DW-1:0] i__pop_data, i__rein_data;
  logic          o__pop, o__reinsert_valid, o__deq_valid, o__rein_ready, o__err;
  logic [IW-1:0] o__pop_flow_id, o__deq_flow_id;
  logic [DW-1:0] o__reinsert_data, o__deq_data;

  always #5 clk = ~clk;

  fifo_bank_reader #(.NUM_FLOWS(NF), .DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i__push_valid(i__push_valid), .i__push_flow_id(i__push_flow_id),
    .i__push_flow_not_full(i__push_flow_not_full),
    .o__pop(o__pop), .o__pop_flow_id(o__pop_flow_id),
    .i__pop_data(i__pop_data), .i__pop_valid(i__pop_valid),
    .o__reinsert_valid(o__reinsert_valid), .o__reinsert_data(o__reinsert_data),
    .o__deq_valid(o__deq_valid), .o__deq_flow_id(o__deq_flow_id), .o__deq_data(o__deq_data),
    .i__deq_ready(i__deq_ready),
    .i__rein_valid(i__rein_valid), .i__rein_flow_id(i__rein_flow_id), .i__rein_data(i__rein_data),
    .o__rein_ready(o__rein_ready), .o__err(o__err)
  );

  int errors = 0, checks = 0;
  typedef struct packed { logic [IW-1:0] flow; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bank model: per-flow circular buffers, head data presented combinationally
  logic [DW-1:0] bq_mem [NF][D];
  int            bq_cnt [NF], bq_rd [NF], bq_wr [NF];
  logic [DW-1:0] push_data;
  logic          force_invalid;
  logic [3:0]    pf;

  assign pf                    = o__pop_flow_id[3:0];
  assign i__pop_data           = bq_mem[pf][bq_rd[pf]];
  assign i__pop_valid          = (bq_cnt[pf] != 0) && !force_invalid;
  assign i__push_flow_not_full = (int'(i__push_flow_id) < NF) && (bq_cnt[i__push_flow_id[3:0]] < D);

  function automatic bit pushf(int f);
    return i__push_valid && i__push_flow_not_full && int'(i__push_flow_id) == f;
  endfunction
  function automatic bit reinf(int f);
    return o__reinsert_valid && int'(o__pop_flow_id) == f;
  endfunction
  function automatic bit popf(int f);
    return o__pop && int'(o__pop_flow_id) == f && bq_cnt[f] > 0;
  endfunction

  always @(posedge clk) begin
    for (int f = 0; f < NF; f++) begin
      if (reset) begin
        bq_cnt[f] <= 0; bq_rd[f] <= 0; bq_wr[f] <= 0;
      end else begin
        if (pushf(f))      bq_mem[f][bq_wr[f]] <= push_data;
        else if (reinf(f)) bq_mem[f][bq_wr[f]] <= o__reinsert_data;
        bq_wr[f]  <= (bq_wr[f] + int'(pushf(f) || reinf(f))) % D;
        bq_rd[f]  <= (bq_rd[f] + int'(popf(f))) % D;
        bq_cnt[f] <= bq_cnt[f] + int'(pushf(f) || reinf(f)) - int'(popf(f));
      end
    end
  end

  // Monitor: every accepted dequeue must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && o__deq_valid && i__deq_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL deq_unexpected: got flow %0d data %0h expected none",
                 o__deq_flow_id, o__deq_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("deq_flow", int'(o__deq_flow_id), int'(e.flow));
        chk("deq_data", int'(o__deq_data), int'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset)
      for (int f = 0; f < NF; f++)
        if (int'(dut.cnt[f]) > D) begin
          errors++;
          $display("FAIL cnt_bound: flow %0d got %0d expected <= %0d", f, dut.cnt[f], D);
        end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(int f, logic [DW-1:0] d);
    i__push_valid = 1'b1; i__push_flow_id = IW'(f); push_data = d;
    cyc();
    i__push_valid = 1'b0;
  endtask

  task automatic expect_deq(int f, logic [DW-1:0] d);
    exp_t e;
    e.flow = IW'(f); e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin cyc(); n++; end
    chk("drain_remaining", exp_q.size(), 0);
    cyc(); cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i__push_valid = 0; i__push_flow_id = '0; push_data = '0;
    i__deq_ready = 1'b1; i__rein_valid = 1'b1; i__rein_flow_id = '0; i__rein_data = 8'h55;
    force_invalid = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst_rein_ready", int'(o__rein_ready), 0);
    chk("rst_pop", int'(o__pop), 0);
    chk("rst_deq_valid", int'(o__deq_valid), 0);
    chk("rst_err", int'(o__err), 0);
    i__rein_valid = 1'b0;
    reset = 1'b0;
    cyc();

    // Single flow, three elements in order
    expect_deq(5, 8'h11); expect_deq(5, 8'h22); expect_deq(5, 8'h33);
    push(5, 8'h11); #1;
    chk("t1_pop", int'(o__pop), 1);
    chk("t1_pop_id", int'(o__pop_flow_id), 5);
    push(5, 8'h22); push(5, 8'h33);
    drain();
    chk("t1_cnt5", int'(dut.cnt[5]), 0);

    // RR round 1: pointer at 5, 15 pops first, then 0 before 3
    i__deq_ready = 1'b0;
    expect_deq(15, 8'hB1); expect_deq(0, 8'hB0); expect_deq(3, 8'hB3);
    push(15, 8'hB1); push(3, 8'hB3); push(0, 8'hB0); #1;
    chk("r1_stall_pop", int'(o__pop), 0);
    i__deq_ready = 1'b1; #1;
    chk("r1_rel_pop", int'(o__pop), 1);
    chk("r1_rel_id", int'(o__pop_flow_id), 0);
    drain();

    // RR round 2 plus 4-cycle stall: pointer at 3, flow 0 pops, then 3, then 15
    i__deq_ready = 1'b0;
    expect_deq(0, 8'hA0); expect_deq(3, 8'hA3); expect_deq(15, 8'hAF);
    push(0, 8'hA0); push(15, 8'hAF); push(3, 8'hA3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pop", int'(o__pop), 0);
      chk("stall_valid", int'(o__deq_valid), 1);
      chk("stall_data", int'(o__deq_data), 'hA0);
      cyc();
    end
    i__deq_ready = 1'b1; #1;
    chk("stall_rel_pop", int'(o__pop), 1);
    chk("stall_rel_id", int'(o__pop_flow_id), 3);
    drain();

    // Reinsert has priority over a pending pop
    expect_deq(3, 8'hC3);
    push(3, 8'hC3);
    drain();
    expect_deq(4, 8'hC4); expect_deq(2, 8'h7E);
    i__push_valid = 1'b1; i__push_flow_id = IW'(4); push_data = 8'hC4;
    cyc();
    i__push_valid = 1'b0;
    i__rein_valid = 1'b1; i__rein_flow_id = IW'(2); i__rein_data = 8'h7E; #1;
    chk("rein_ready", int'(o__rein_ready), 1);
    chk("rein_valid", int'(o__reinsert_valid), 1);
    chk("rein_pop", int'(o__pop), 0);
    chk("rein_id", int'(o__pop_flow_id), 2);
    chk("rein_data", int'(o__reinsert_data), 'h7E);
    cyc();
    i__rein_valid = 1'b0; #1;
    chk("rein_next_pop", int'(o__pop), 1);
    chk("rein_next_id", int'(o__pop_flow_id), 4);
    chk("rein_cnt2", int'(dut.cnt[2]), 1);
    cyc(); #1;
    chk("rein_after_id", int'(o__pop_flow_id), 2);
    drain();

    // Same-cycle push and reinsert to one flow: reinsert deferred a cycle
    expect_deq(6, 8'hD6); expect_deq(6, 8'h5A);
    i__push_valid = 1'b1; i__push_flow_id = IW'(6); push_data = 8'hD6;
    i__rein_valid = 1'b1; i__rein_flow_id = IW'(6); i__rein_data = 8'h5A; #1;
    chk("coll_ready", int'(o__rein_ready), 0);
    chk("coll_valid", int'(o__reinsert_valid), 0);
    cyc();
    i__push_valid = 1'b0; #1;
    chk("coll_next_ready", int'(o__rein_ready), 1);
    chk("coll_next_pop", int'(o__pop), 0);
    cyc();
    i__rein_valid = 1'b0;
    drain();

    // Full flow and out-of-range reinsert are refused
    i__deq_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      expect_deq(1, 8'(8'h40 + i));
      push(1, 8'(8'h40 + i));
    end
    #1;
    chk("full_cnt1", int'(dut.cnt[1]), 10);
    i__rein_valid = 1'b1; i__rein_flow_id = IW'(1); i__rein_data = 8'h99; #1;
    chk("full_rein_ready", int'(o__rein_ready), 0);
    i__rein_flow_id = IW'(16); #1;
    chk("oor_rein_ready", int'(o__rein_ready), 0);
    i__rein_valid = 1'b0;
    push(1, 8'hEE); #1;
    chk("full_push_cnt1", int'(dut.cnt[1]), 10);
    i__deq_ready = 1'b1;
    drain();

    // Pop against an invalid bank head sets sticky error; reset discards output register
    i__deq_ready = 1'b0;
    force_invalid = 1'b1;
    push(7, 8'hE7); #1;
    chk("err_pop", int'(o__pop), 1);
    cyc();
    force_invalid = 1'b0; #1;
    chk("err_set", int'(o__err), 1);
    chk("err_deq_valid", int'(o__deq_valid), 1);
    chk("err_deq_flow", int'(o__deq_flow_id), 7);
    chk("err_deq_data", int'(o__deq_data), 'hE7);
    cyc(); cyc(); cyc();
    chk("err_sticky", int'(o__err), 1);
    reset = 1'b1;
    cyc(); #1;
    chk("rst2_deq_valid", int'(o__deq_valid), 0);
    chk("rst2_err", int'(o__err), 0);
    reset = 1'b0;
    cyc();
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
